// File: rtl/flash_arbiter_if.sv
// flash_arbiter_if
// Bundles every non-clock/reset signal of flash_arbiter: the two-requester
// side (req/reqOp/reqPage/reqLen/gnt/done, write and read byte streams) and
// the flash controller side (flCmd/flPage/flBusy/read strobe/FIFO strobes).
// Modports:
//   slave  - the arbiter itself (takes requests and flash status, drives
//            grants, byte streams and flash commands)
//   master - the environment (requesters plus flash controller)
interface flash_arbiter_if;
  logic [1:0]  req;
  logic [3:0]  reqOp;
  logic [31:0] reqPage;
  logic [31:0] reqLen;
  logic [1:0]  gnt;
  logic [1:0]  done;
  logic [7:0]  wrData;
  logic        wrValid;
  logic        wrReady;
  logic [7:0]  rdData;
  logic        rdValid;
  logic        rdLast;
  logic [2:0]  flCmd;
  logic [15:0] flPage;
  logic        flBusy;
  logic [7:0]  flReadData;
  logic        flRdRdy;
  logic [7:0]  flWriteData;
  logic        flFifoWrReq;
  logic        flFifoClr;

  modport slave (
    input  req, reqOp, reqPage, reqLen, wrData, wrValid,
    input  flBusy, flReadData, flRdRdy,
    output gnt, done, wrReady, rdData, rdValid, rdLast,
    output flCmd, flPage, flWriteData, flFifoWrReq, flFifoClr
  );

  modport master (
    output req, reqOp, reqPage, reqLen, wrData, wrValid,
    output flBusy, flReadData, flRdRdy,
    input  gnt, done, wrReady, rdData, rdValid, rdLast,
    input  flCmd, flPage, flWriteData, flFifoWrReq, flFifoClr
  );
endinterface

// File: rtl/flash_arbiter.sv
// flash_arbiter
// Arbitrates two requesters onto one flash controller. A granted requester
// owns the controller until its one-cycle done pulse. Reads stream bytes back
// (rdValid/rdData/rdLast); page writes first load bytes into the flash FIFO,
// then issue the write; erases just issue and wait for the controller.
// Ports:
//   clk    - single clock, rising edge
//   reset  - synchronous, active-high
//   bus    - flash_arbiter_if.slave (request, byte stream and flash signals)
// Parameter:
//   MAX_WR - maximum bytes per page program; write lengths clamp to it
// Configuration macro:
//   FLASH_ARB_RR_EN - defined: round-robin (last-served requester loses ties);
//                     undefined: fixed priority, requester 0 always wins.
module flash_arbiter #(
  parameter int MAX_WR = 256
) (
  input  logic            clk,
  input  logic            reset,
  flash_arbiter_if.slave  bus
);

  localparam logic [1:0]  OP_READ  = 2'd0;
  localparam logic [1:0]  OP_WRITE = 2'd1;
  localparam logic [15:0] MAX_LEN  = 16'(MAX_WR);

  typedef enum logic [2:0] {IDLE, LOAD, ISSUE, RUN, DRAIN, FIN} state_t;

  state_t      state_reg, state_next;
  logic        owner_reg;
  logic [1:0]  op_reg;
  logic [15:0] page_reg;
  logic [15:0] len_reg;
  logic [15:0] count_reg;
  logic [7:0]  rd_data_reg;
  logic        rd_valid_reg;
  logic        rd_last_reg;

  // Request selection
  logic        grant_valid;
  logic        start;
  logic        pick;
  logic [1:0]  sel_op;
  logic [15:0] sel_page;
  logic [15:0] sel_len_raw;
  logic [15:0] sel_len;
  logic        sel_no_data;

  // Byte movement
  logic        fifo_wr;
  logic        rd_take;
  logic        last_byte;

`ifdef FLASH_ARB_RR_EN
  // Requester currently holding the higher priority; the one just served
  // is demoted so the other wins the next tie.
  logic prio_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      prio_reg <= 1'b0;
    end else if (start) begin
      prio_reg <= ~pick;
    end
  end

  always_comb begin
    pick = bus.req[1] && (prio_reg || !bus.req[0]);
  end
`else
  always_comb begin
    pick = !bus.req[0];
  end
`endif

  always_comb begin
    grant_valid = !reset && (bus.req != 2'b00) && !bus.flBusy;
    start       = (state_reg == IDLE) && grant_valid;
    sel_op      = pick ? bus.reqOp[3:2]     : bus.reqOp[1:0];
    sel_page    = pick ? bus.reqPage[31:16] : bus.reqPage[15:0];
    sel_len_raw = pick ? bus.reqLen[31:16]  : bus.reqLen[15:0];
    sel_len     = sel_len_raw;
    if ((sel_op == OP_WRITE) && (sel_len_raw > MAX_LEN)) begin
      sel_len = MAX_LEN;
    end
    // Zero-length reads/writes finish without touching the flash.
    // Erases ignore the length entirely.
    sel_no_data = ((sel_op == OP_READ) || (sel_op == OP_WRITE)) && (sel_len == 16'd0);
  end

  always_comb begin
    fifo_wr   = (state_reg == LOAD) && bus.wrValid && (count_reg < len_reg);
    rd_take   = (state_reg == RUN) && (op_reg == OP_READ) && bus.flRdRdy;
    last_byte = rd_take && (count_reg == len_reg - 16'd1);
  end

  function automatic logic [2:0] cmd_code(input logic [1:0] op);
    case (op)
      2'd0:    cmd_code = 3'd3;
      2'd1:    cmd_code = 3'd2;
      2'd2:    cmd_code = 3'd1;
      default: cmd_code = 3'd4;
    endcase
  endfunction

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= IDLE;
      owner_reg    <= 1'b0;
      op_reg       <= 2'd0;
      page_reg     <= 16'd0;
      len_reg      <= 16'd0;
      count_reg    <= 16'd0;
      rd_data_reg  <= 8'd0;
      rd_valid_reg <= 1'b0;
      rd_last_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      rd_valid_reg <= rd_take;
      rd_last_reg  <= last_byte;
      if (rd_take) begin
        rd_data_reg <= bus.flReadData;
      end
      if (start) begin
        owner_reg <= pick;
        op_reg    <= sel_op;
        page_reg  <= sel_page;
        len_reg   <= sel_len;
        count_reg <= 16'd0;
      end else if (fifo_wr || rd_take) begin
        count_reg <= count_reg + 16'd1;
      end
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (start) begin
          if (sel_no_data)              state_next = FIN;
          else if (sel_op == OP_WRITE)  state_next = LOAD;
          else                          state_next = ISSUE;
        end
      end
      LOAD: begin
        if (count_reg == len_reg) state_next = ISSUE;
      end
      ISSUE: begin
        if (bus.flBusy) state_next = RUN;
      end
      RUN: begin
        if (op_reg == OP_READ) begin
          // A controller that goes idle before delivering every byte would
          // otherwise leave the owner stuck; finish the operation instead.
          if (last_byte)        state_next = DRAIN;
          else if (!bus.flBusy) state_next = FIN;
        end else if (!bus.flBusy) begin
          state_next = FIN;
        end
      end
      DRAIN: begin
        if (!bus.flBusy) state_next = FIN;
      end
      FIN:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    bus.gnt         = 2'b00;
    bus.done        = 2'b00;
    bus.wrReady     = 1'b0;
    bus.flCmd       = 3'd0;
    bus.flPage      = 16'd0;
    bus.flWriteData = 8'd0;
    bus.flFifoWrReq = 1'b0;
    bus.flFifoClr   = 1'b0;
    if (state_reg != IDLE) begin
      bus.gnt = owner_reg ? 2'b10 : 2'b01;
    end
    case (state_reg)
      IDLE: begin
        bus.flFifoClr = start && (sel_op == OP_WRITE) && !sel_no_data;
      end
      LOAD: begin
        bus.wrReady     = count_reg < len_reg;
        bus.flFifoWrReq = fifo_wr;
        bus.flWriteData = fifo_wr ? bus.wrData : 8'd0;
      end
      ISSUE: begin
        bus.flCmd  = cmd_code(op_reg);
        bus.flPage = page_reg;
      end
      RUN: begin
        if (op_reg == OP_READ) begin
          bus.flCmd  = 3'd3;
          bus.flPage = page_reg;
        end
      end
      FIN: begin
        bus.done = owner_reg ? 2'b10 : 2'b01;
      end
      default: ;
    endcase
  end

  assign bus.rdData  = rd_data_reg;
  assign bus.rdValid = rd_valid_reg;
  assign bus.rdLast  = rd_last_reg;

endmodule

// File: tb/tb_flash_arbiter.sv
// tb_flash_arbiter
// Directed bench for flash_arbiter: a small flash controller behaviour is
// driven per cycle from each scenario task, and outputs are sampled 3 time
// units after the rising edge. Expected values are hand-derived.
module tb_flash_arbiter;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  flash_arbiter_if bus_if ();

  flash_arbiter #(.MAX_WR(256)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  task automatic idle_inputs();
    bus_if.req        = 2'b00;
    bus_if.reqOp      = 4'd0;
    bus_if.reqPage    = 32'd0;
    bus_if.reqLen     = 32'd0;
    bus_if.wrData     = 8'd0;
    bus_if.wrValid    = 1'b0;
    bus_if.flBusy     = 1'b0;
    bus_if.flReadData = 8'd0;
    bus_if.flRdRdy    = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #3;
    checks++; if (bus_if.gnt !== 2'b00) begin errors++; $display("FAIL reset_gnt got %b want 00", bus_if.gnt); end
    checks++; if (bus_if.done !== 2'b00) begin errors++; $display("FAIL reset_done got %b want 00", bus_if.done); end
    checks++; if (bus_if.flCmd !== 3'd0) begin errors++; $display("FAIL reset_flcmd got %0d want 0", bus_if.flCmd); end
    checks++; if (bus_if.rdValid !== 1'b0) begin errors++; $display("FAIL reset_rdvalid got %b want 0", bus_if.rdValid); end
    checks++; if (bus_if.wrReady !== 1'b0) begin errors++; $display("FAIL reset_wrready got %b want 0", bus_if.wrReady); end
    checks++; if (bus_if.flFifoClr !== 1'b0) begin errors++; $display("FAIL reset_fifoclr got %b want 0", bus_if.flFifoClr); end
    @(posedge clk); #1;
    reset = 1'b0;
    $display("reset: released");
  endtask

  // Both requesters ask for chip erase continuously; record who gets each done.
  task automatic test_erase_arb();
    int s;
    int nd;
    bit bad_cmd;
    logic [1:0] owners [4];
    logic [1:0] exp_own [4];
`ifdef FLASH_ARB_RR_EN
    exp_own = '{2'b01, 2'b10, 2'b01, 2'b10};
`else
    exp_own = '{2'b01, 2'b01, 2'b01, 2'b01};
`endif
    s = -1; nd = 0; bad_cmd = 1'b0;
    owners = '{2'b00, 2'b00, 2'b00, 2'b00};
    idle_inputs();
    bus_if.req   = 2'b11;
    bus_if.reqOp = {2'd2, 2'd2};
    for (int cyc = 0; cyc < 200 && nd < 4; cyc++) begin
      bus_if.flBusy = (s >= 0) && (cyc >= s + 1) && (cyc < s + 3);
      #2;
      if (bus_if.flCmd != 3'd0) begin
        if (bus_if.flCmd !== 3'd1) bad_cmd = 1'b1;
        if (s < 0) s = cyc;
      end
      if (bus_if.done != 2'b00) begin
        owners[nd] = bus_if.done;
        nd++;
        s = -1;
      end
      @(posedge clk); #1;
    end
    idle_inputs();
    checks++; if (nd !== 4) begin errors++; $display("FAIL erase_count got %0d want 4", nd); end
    checks++; if (bad_cmd !== 1'b0) begin errors++; $display("FAIL erase_flcmd got non-1 command want 1"); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (owners[i] !== exp_own[i]) begin
        errors++; $display("FAIL erase_owner%0d got %b want %b", i, owners[i], exp_own[i]);
      end
      $display("erase: grant %0d owner %b", i, owners[i]);
    end
  endtask

  // Read page 0x0012 len 4; the controller supplies A0..A4, A4 must be dropped.
  task automatic test_read();
    int s;
    int nrd;
    int nlast;
    int last_idx;
    int done_cyc;
    logic [1:0] done_val;
    logic [1:0] gnt_at_issue;
    bit bad_cmd;
    logic [7:0] got [8];
    logic [7:0] want;
    s = -1; nrd = 0; nlast = 0; last_idx = -1; done_cyc = -1;
    done_val = 2'b00; gnt_at_issue = 2'b00; bad_cmd = 1'b0;
    for (int i = 0; i < 8; i++) got[i] = 8'd0;
    idle_inputs();
    bus_if.req     = 2'b01;
    bus_if.reqOp   = 4'b1100;
    bus_if.reqPage = {16'h0555, 16'h0012};
    bus_if.reqLen  = {16'd9, 16'd4};
    for (int cyc = 0; cyc < 40 && done_cyc < 0; cyc++) begin
      if (cyc == 1) bus_if.req = 2'b00;
      bus_if.flBusy = (s >= 0) && (cyc >= s + 1) && (cyc < s + 9);
      if ((s >= 0) && (cyc >= s + 2) && (cyc <= s + 6)) begin
        bus_if.flRdRdy    = 1'b1;
        bus_if.flReadData = 8'(8'hA0 + (cyc - s - 2));
      end else begin
        bus_if.flRdRdy    = 1'b0;
      end
      #2;
      if (bus_if.flCmd != 3'd0) begin
        if ((bus_if.flCmd !== 3'd3) || (bus_if.flPage !== 16'h0012)) bad_cmd = 1'b1;
        if (s < 0) begin s = cyc; gnt_at_issue = bus_if.gnt; end
      end
      if ((s >= 0) && (cyc >= s + 6) && (bus_if.flCmd !== 3'd0)) bad_cmd = 1'b1;
      if (bus_if.rdValid === 1'b1) begin
        if (nrd < 8) got[nrd] = bus_if.rdData;
        if (bus_if.rdLast === 1'b1) begin last_idx = nrd; nlast++; end
        nrd++;
      end
      if (bus_if.done != 2'b00) begin done_cyc = cyc; done_val = bus_if.done; end
      @(posedge clk); #1;
    end
    idle_inputs();
    checks++; if (s < 0) begin errors++; $display("FAIL read_issue got no command want flCmd 3"); end
    checks++; if (gnt_at_issue !== 2'b01) begin errors++; $display("FAIL read_gnt got %b want 01", gnt_at_issue); end
    checks++; if (bad_cmd !== 1'b0) begin errors++; $display("FAIL read_flcmd got wrong cmd/page want 3/0012 then 0"); end
    checks++; if (nrd !== 4) begin errors++; $display("FAIL read_count got %0d want 4", nrd); end
    for (int i = 0; i < 4; i++) begin
      want = 8'(8'hA0 + i);
      checks++;
      if (got[i] !== want) begin errors++; $display("FAIL read_byte%0d got %h want %h", i, got[i], want); end
    end
    checks++; if ((last_idx !== 3) || (nlast !== 1)) begin errors++; $display("FAIL read_last got idx %0d n %0d want idx 3 n 1", last_idx, nlast); end
    checks++; if (done_val !== 2'b01) begin errors++; $display("FAIL read_done got %b want 01", done_val); end
    checks++; if (done_cyc !== s + 10) begin errors++; $display("FAIL read_done_cycle got %0d want %0d", done_cyc, s + 10); end
    $display("read: %0d bytes, last idx %0d, done %b", nrd, last_idx, done_val);
  endtask

  // Page write by one requester; byte k carries 8'h11*(k+1).
  task automatic test_write(input bit owner, input int len, input int exp_n);
    int s;
    int nclr;
    int nwr;
    int nwr_at_cmd;
    int done_cyc;
    logic [1:0] done_val;
    logic [1:0] exp_done;
    bit bad_cmd;
    bit bad_data;
    logic [15:0] page;
    logic [7:0] exp_byte;
    s = -1; nclr = 0; nwr = 0; nwr_at_cmd = -1; done_cyc = -1;
    done_val = 2'b00; bad_cmd = 1'b0; bad_data = 1'b0;
    page = owner ? 16'h0100 : 16'h0200;
    exp_done = owner ? 2'b10 : 2'b01;
    idle_inputs();
    bus_if.req     = exp_done;
    bus_if.reqOp   = owner ? 4'b0100 : 4'b0001;
    bus_if.reqPage = owner ? {page, 16'h0000} : {16'h0000, page};
    bus_if.reqLen  = owner ? {16'(len), 16'd0} : {16'd0, 16'(len)};
    for (int cyc = 0; cyc < 1000 && done_cyc < 0; cyc++) begin
      if (cyc == 1) bus_if.req = 2'b00;
      bus_if.wrValid = (cyc % 4) != 3;
      bus_if.wrData  = 8'(8'h11 * (nwr + 1));
      bus_if.flBusy  = (s >= 0) && (cyc >= s + 1) && (cyc < s + 4);
      #2;
      if (bus_if.flFifoClr === 1'b1) nclr++;
      if (bus_if.flFifoWrReq === 1'b1) begin
        exp_byte = 8'(8'h11 * (nwr + 1));
        if (bus_if.flWriteData !== exp_byte) bad_data = 1'b1;
        nwr++;
      end
      if (bus_if.flCmd != 3'd0) begin
        if ((bus_if.flCmd !== 3'd2) || (bus_if.flPage !== page)) bad_cmd = 1'b1;
        if (s < 0) begin s = cyc; nwr_at_cmd = nwr; end
      end
      if (bus_if.done != 2'b00) begin done_cyc = cyc; done_val = bus_if.done; end
      @(posedge clk); #1;
    end
    idle_inputs();
    checks++; if (s < 0) begin errors++; $display("FAIL write_issue len %0d got no command want flCmd 2", len); end
    checks++; if (nclr !== 1) begin errors++; $display("FAIL write_clr len %0d got %0d want 1", len, nclr); end
    checks++; if (nwr !== exp_n) begin errors++; $display("FAIL write_count len %0d got %0d want %0d", len, nwr, exp_n); end
    checks++; if (nwr_at_cmd !== exp_n) begin errors++; $display("FAIL write_before_cmd len %0d got %0d want %0d", len, nwr_at_cmd, exp_n); end
    checks++; if (bad_data !== 1'b0) begin errors++; $display("FAIL write_data len %0d got wrong byte want 11*(k+1)", len); end
    checks++; if (bad_cmd !== 1'b0) begin errors++; $display("FAIL write_flcmd len %0d got wrong cmd/page want 2/%h", len, page); end
    checks++; if (done_val !== exp_done) begin errors++; $display("FAIL write_done len %0d got %b want %b", len, done_val, exp_done); end
    $display("write: len %0d, %0d bytes, done %b", len, nwr, done_val);
  endtask

  task automatic test_len_zero();
    int done_cyc;
    logic [1:0] done_val;
    bit bad;
    done_cyc = -1; done_val = 2'b00; bad = 1'b0;
    idle_inputs();
    bus_if.req    = 2'b01;
    bus_if.reqOp  = 4'b0000;
    bus_if.reqLen = 32'd0;
    for (int cyc = 0; cyc < 4; cyc++) begin
      if (cyc == 1) bus_if.req = 2'b00;
      #2;
      if ((bus_if.flCmd !== 3'd0) || (bus_if.rdValid !== 1'b0)) bad = 1'b1;
      if ((bus_if.done != 2'b00) && (done_cyc < 0)) begin done_cyc = cyc; done_val = bus_if.done; end
      @(posedge clk); #1;
    end
    idle_inputs();
    checks++; if ((done_cyc < 0) || (done_cyc > 2)) begin errors++; $display("FAIL len0_done_cycle got %0d want 0..2", done_cyc); end
    checks++; if (done_val !== 2'b01) begin errors++; $display("FAIL len0_done got %b want 01", done_val); end
    checks++; if (bad !== 1'b0) begin errors++; $display("FAIL len0_activity got flCmd/rdValid active want idle"); end
    $display("len0: done %b at cycle %0d", done_val, done_cyc);
  endtask

  task automatic test_reset_mid_read();
    int s;
    bit reached;
    bit bad_hold;
    int gnt_cyc;
    s = -1; reached = 1'b0; bad_hold = 1'b0; gnt_cyc = -1;
    idle_inputs();
    bus_if.req     = 2'b01;
    bus_if.reqOp   = 4'b0000;
    bus_if.reqPage = {16'h0000, 16'h0033};
    bus_if.reqLen  = {16'd0, 16'd8};
    for (int cyc = 0; cyc < 20 && !reached; cyc++) begin
      bus_if.flBusy  = (s >= 0) && (cyc >= s + 1);
      bus_if.flRdRdy = (s >= 0) && (cyc >= s + 2) && (cyc <= s + 3);
      bus_if.flReadData = 8'h5A;
      if ((s >= 0) && (cyc == s + 4)) begin
        reached = 1'b1;
        reset = 1'b1;
      end
      #2;
      if ((bus_if.flCmd != 3'd0) && (s < 0)) s = cyc;
      @(posedge clk); #1;
    end
    reset = 1'b0;
    #2;
    checks++; if (!reached) begin errors++; $display("FAIL midreset_reach got no RUN want RUN"); end
    checks++; if (bus_if.gnt !== 2'b00) begin errors++; $display("FAIL midreset_gnt got %b want 00", bus_if.gnt); end
    checks++; if (bus_if.flCmd !== 3'd0) begin errors++; $display("FAIL midreset_flcmd got %0d want 0", bus_if.flCmd); end
    checks++; if (bus_if.rdValid !== 1'b0) begin errors++; $display("FAIL midreset_rdvalid got %b want 0", bus_if.rdValid); end
    checks++; if (bus_if.done !== 2'b00) begin errors++; $display("FAIL midreset_done got %b want 00", bus_if.done); end
    @(posedge clk); #1;
    // Controller still busy with the abandoned read: no grant, no done.
    bus_if.flRdRdy = 1'b0;
    for (int cyc = 0; cyc < 4; cyc++) begin
      #2;
      if ((bus_if.gnt !== 2'b00) || (bus_if.done !== 2'b00)) bad_hold = 1'b1;
      @(posedge clk); #1;
    end
    checks++; if (bad_hold !== 1'b0) begin errors++; $display("FAIL midreset_hold got grant/done while busy want none"); end
    bus_if.flBusy = 1'b0;
    bus_if.reqLen = 32'd0;
    for (int cyc = 0; cyc < 4 && gnt_cyc < 0; cyc++) begin
      #2;
      if (bus_if.gnt === 2'b01) gnt_cyc = cyc;
      @(posedge clk); #1;
    end
    bus_if.req = 2'b00;
    repeat (2) @(posedge clk);
    #1;
    idle_inputs();
    checks++; if ((gnt_cyc < 0) || (gnt_cyc > 2)) begin errors++; $display("FAIL midreset_regrant got cycle %0d want 0..2", gnt_cyc); end
    $display("midreset: regrant at cycle %0d after busy low", gnt_cyc);
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_erase_arb();
    test_read();
    test_write(1'b1, 3, 3);
    test_write(1'b0, 300, 256);
    test_len_zero();
    test_reset_mid_read();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/flash_arbiter.md
FLASH_ARBITER -- requirements
Module: flash_arbiter

Interface
REQ-001 Parameter: MAX_WR, 256, maximum bytes per page program; reqLen for writes clamps to this.
REQ-002 clk  in  1  single clock; all logic on rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 req  in  2  per-requester request; bit0 = requester 0.
REQ-005 reqOp  in  4  2 bits per requester: 0 read, 1 page write, 2 chip erase, 3 block erase.
REQ-006 reqPage  in  32  16-bit page per requester.
REQ-007 reqLen  in  32  16-bit byte count per requester (read/write only).
REQ-008 gnt  out  2  one-hot owner, held from grant until done.
REQ-009 done  out  2  one-cycle completion pulse to owner.
REQ-010 wrData  in  8  write byte from owner.
REQ-011 wrValid  in  1  wrData valid.
REQ-012 wrReady  out  1  arbiter accepts wrData this cycle.
REQ-013 rdData  out  8  read byte to owner.
REQ-014 rdValid  out  1  rdData valid, one cycle per byte.
REQ-015 rdLast  out  1  with rdValid on final byte.
REQ-016 flCmd  out  3  flash controller command: 0 NOOP, 1 chip erase, 2 write, 3 read, 4 block erase.
REQ-017 flPage  out  16  flash controller page.
REQ-018 flBusy  in  1  flash controller busy.
REQ-019 flReadData  in  8  flash controller read byte.
REQ-020 flRdRdy  in  1  flash controller read strobe.
REQ-021 flWriteData  out  8  flash FIFO write data.
REQ-022 flFifoWrReq  out  1  flash FIFO write strobe.
REQ-023 flFifoClr  out  1  flash FIFO clear pulse.

Function
REQ-024 States IDLE, LOAD, ISSUE, RUN, DRAIN, FIN; flCmd SHALL be NOOP in all states except ISSUE, and RUN for reads.
REQ-025 IDLE: grant only when some req bit set and flBusy=0; latch op, page, len (write len clamped to MAX_WR); len=0 -> FIN with no flash access; write -> LOAD with flFifoClr=1 that cycle; else -> ISSUE.
REQ-026 LOAD: wrReady=1 while count<len; each wrValid&wrReady drives flFifoWrReq=1, flWriteData=wrData same cycle; count==len -> ISSUE.
REQ-027 ISSUE: flCmd=mapped code, flPage=latched page, held until flBusy=1 sampled -> RUN.
REQ-028 RUN non-read: wait flBusy=0 -> FIN.
REQ-029 RUN read: flCmd=3 held; each flRdRdy -> rdValid=1, rdData=flReadData one cycle later; len-th byte also asserts rdLast -> DRAIN.
REQ-030 DRAIN: flCmd=0; further flRdRdy discarded (no rdValid); flBusy=0 -> FIN.
REQ-031 FIN: done[owner]=1 one cycle, gnt cleared, -> IDLE; next grant earliest the following cycle.
REQ-032 req deasserted mid-operation is ignored; operation completes and done pulses.
REQ-033 Byte counters 16 bits, no wrap; reqOp/reqPage/reqLen changes after grant have no effect.

Reset
REQ-034 Reset: state IDLE, all outputs 0 (flCmd NOOP), counters 0, round-robin pointer to requester 0.
REQ-035 Reset mid-operation abandons it without done; in-flight flash activity is not aborted; grants resume only after flBusy=0.

Configuration
REQ-036 FLASH_ARB_RR_EN defined: round-robin, last-served requester lowest priority; undefined: fixed priority, requester 0 always wins.

Verification
REQ-037 req=01 read page 0x0012 len 4, model returns A0..A4 -> flCmd=3/flPage=0x0012, rdData A0..A3, rdLast on A3, A4 suppressed, done=01 after flBusy falls.
REQ-038 req=10 write len 3 bytes 11,22,33 -> one flFifoClr, three flFifoWrReq 11/22/33, then flCmd=2 until busy, done=10.
REQ-039 Write len 300 -> exactly 256 flFifoWrReq, then flCmd=2.
REQ-040 req=11 chip erase, held continuously -> undefined macro: grants 01 every time; defined: 01,10,01,10.
REQ-041 Read len 0 -> done pulse within 2 cycles, flCmd stays 0, no rdValid.
REQ-042 reset during RUN read with flBusy=1 -> outputs 0 next cycle, no done; new req not granted until flBusy=0.
